// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode mnemonics, controller states
// and the start of the illegal opcode range.
`timescale 1ns/1ps
package alu_seq_pkg;

   typedef enum logic [3:0] {
      ADD = 4'd0,
      SUB = 4'd1,
      AND = 4'd2,
      IOR = 4'd3,
      NOT = 4'd4,
      XOR = 4'd5,
      LSL = 4'd6,
      LSR = 4'd7,
      SLT = 4'd8,
      SEQ = 4'd9,
      MUL = 4'd10,
      ASR = 4'd11
   } op_mne;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_RESP
   } alu_state_t;

   // Opcodes 12..15 carry no operation; anything at or above this code is illegal.
   localparam logic [3:0] ILLEGAL_OP_MIN = 4'd12;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: W steps after start, 2W-bit product.
// The product port shows the result of the step in progress, so it is final while done=1.
`timescale 1ns/1ps
module alu_mul_iter
   import alu_seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic [W-1:0]  mcand;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic [CW-1:0] count;
   logic [W:0]    sum;

   // One shift-add step: add the multiplicand when the current multiplier bit is set,
   // then shift the whole {hi,lo} pair right with the add carry entering at the top.
   always_comb begin
      sum     = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {W{1'b0}})};
      product = {sum, lo[W-1:1]};
   end

   assign done = busy && (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand <= '0;
         hi    <= '0;
         lo    <= '0;
         count <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         mcand <= a;
         hi    <= '0;
         lo    <= b;
         count <= '0;
         busy  <= 1'b1;
      end else if (busy) begin
         hi    <= product[2*W-1:W];
         lo    <= product[W-1:0];
         count <= count + CW'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake, registered result and flag registers.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise MUL is an illegal opcode.
`timescale 1ns/1ps
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int W   = 8,
   parameter int Ops = 4
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic           In_valid,
   output logic           In_ready,
   input  logic [W-1:0]   InputA,
   input  logic [W-1:0]   InputB,
   input  logic [Ops-1:0] OP,
   output logic           Out_valid,
   input  logic           Out_ready,
   output logic [W-1:0]   Out,
   output logic [W-1:0]   OutHi,
   output logic           Cond,
   output logic           Zero,
   output logic           Carry,
   output logic           Err
);

   localparam logic [W:0] W_VAL = (W + 1)'(W);

   alu_state_t     state;
   alu_state_t     state_next;
   logic [3:0]     op_code;
   logic           base_legal;
   logic           op_ok;
   logic           is_mul;
   logic           accept;
   logic           shift_big;
   logic [W-1:0]   res;
   logic [W:0]     sum_ext;
   logic           carry_next;
   logic           cond_next;
   logic           mul_done;
   logic [2*W-1:0] mul_product;

   assign op_code    = OP[3:0];
   assign base_legal = ((OP >> 4) == '0) && (op_code < ILLEGAL_OP_MIN);
   assign In_ready   = (state == ST_IDLE) || ((state == ST_RESP) && Out_ready);
   assign accept     = In_valid && In_ready;
   assign Out_valid  = (state == ST_RESP);
   assign shift_big  = ({1'b0, InputB} >= W_VAL);

`ifdef ALU_MUL_EN
   logic mul_busy;

   assign op_ok  = base_legal;
   assign is_mul = base_legal && (op_code == MUL);

   alu_mul_iter #(.W(W)) u_mul (
      .clk     (Clk),
      .rst_n   (Reset_n),
      .start   (accept && is_mul),
      .a       (InputA),
      .b       (InputB),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   assign op_ok       = base_legal && (op_code != MUL);
   assign is_mul      = 1'b0;
   assign mul_done    = 1'b0;
   assign mul_product = '0;
`endif

   // Single-cycle result for whatever is presented on the inputs; only used on accept.
   always_comb begin
      res        = '0;
      sum_ext    = '0;
      carry_next = Carry;
      cond_next  = Cond;
      case (op_mne'(op_code))
         ADD: begin
            sum_ext    = {1'b0, InputA} + {1'b0, InputB};
            res        = sum_ext[W-1:0];
            carry_next = sum_ext[W];
         end
         SUB: begin
            sum_ext    = {1'b0, InputA} + {1'b0, ~InputB} + {{W{1'b0}}, 1'b1};
            res        = sum_ext[W-1:0];
            carry_next = sum_ext[W];
         end
         AND: res = InputA & InputB;
         IOR: res = InputA | InputB;
         NOT: res = ~InputA;
         XOR: res = InputA ^ InputB;
         LSL: res = shift_big ? '0 : (InputA << InputB);
         LSR: res = shift_big ? '0 : (InputA >> InputB);
         ASR: res = shift_big ? {W{InputA[W-1]}} : W'($signed(InputA) >>> InputB);
         SLT: begin
            res       = {{(W-1){1'b0}}, (InputA < InputB)};
            cond_next = (InputA < InputB);
         end
         SEQ: begin
            res       = {{(W-1){1'b0}}, (InputA == InputB)};
            cond_next = (InputA == InputB);
         end
         default: res = '0;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A result leaving RESP can be replaced on the same edge, so single-cycle ops stream.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_next = is_mul ? ST_MUL : ST_RESP;
            end
         end
         ST_MUL: begin
            if (mul_done) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (accept) begin
               state_next = is_mul ? ST_MUL : ST_RESP;
            end else if (Out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Result and flag registers; Carry and Cond hold unless their own ops update them.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Out   <= '0;
         OutHi <= '0;
         Cond  <= 1'b0;
         Zero  <= 1'b0;
         Carry <= 1'b0;
         Err   <= 1'b0;
      end else if (accept) begin
         if (!op_ok) begin
            Out   <= '0;
            OutHi <= '0;
            Zero  <= 1'b1;
            Err   <= 1'b1;
         end else if (is_mul) begin
            Err <= 1'b0;
         end else begin
            Out   <= res;
            OutHi <= '0;
            Zero  <= (res == '0);
            Carry <= carry_next;
            Cond  <= cond_next;
            Err   <= 1'b0;
         end
      end else if ((state == ST_MUL) && mul_done) begin
         Out   <= mul_product[W-1:0];
         OutHi <= mul_product[2*W-1:W];
         Zero  <= (mul_product == '0);
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=8): streamed vector table plus multiply, backpressure
// and reset-abort sequences. Expectations follow ALU_MUL_EN when it is defined.
`timescale 1ns/1ps
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic       Clk;
   logic       Reset_n;
   logic       In_valid;
   logic       In_ready;
   logic [7:0] InputA;
   logic [7:0] InputB;
   logic [3:0] OP;
   logic       Out_valid;
   logic       Out_ready;
   logic [7:0] Out;
   logic [7:0] OutHi;
   logic       Cond;
   logic       Zero;
   logic       Carry;
   logic       Err;

   int checks;
   int errors;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] out;
      logic       cond;
      logic       zero;
      logic       carry;
      logic       err;
   } vec_t;

   vec_t vq[$];

`ifdef ALU_MUL_EN
   localparam logic [7:0] MUL_LO   = 8'h01;
   localparam logic [7:0] MUL_HI   = 8'hFE;
   localparam logic       MUL_ZERO = 1'b0;
   localparam logic       MUL_ERR  = 1'b0;
`else
   localparam logic [7:0] MUL_LO   = 8'h00;
   localparam logic [7:0] MUL_HI   = 8'h00;
   localparam logic       MUL_ZERO = 1'b1;
   localparam logic       MUL_ERR  = 1'b1;
`endif

   alu_seq #(.W(8), .Ops(4)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .In_valid  (In_valid),
      .In_ready  (In_ready),
      .InputA    (InputA),
      .InputB    (InputB),
      .OP        (OP),
      .Out_valid (Out_valid),
      .Out_ready (Out_ready),
      .Out       (Out),
      .OutHi     (OutHi),
      .Cond      (Cond),
      .Zero      (Zero),
      .Carry     (Carry),
      .Err       (Err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      OP       = op;
      InputA   = a;
      InputB   = b;
      In_valid = 1'b1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic checkIdleReset(input string tag);
      checkOutput({tag, " Out_valid"}, Out_valid, 0);
      checkOutput({tag, " In_ready"}, In_ready, 1);
      checkOutput({tag, " Out"}, Out, 0);
      checkOutput({tag, " OutHi"}, OutHi, 0);
      checkOutput({tag, " Cond"}, Cond, 0);
      checkOutput({tag, " Zero"}, Zero, 0);
      checkOutput({tag, " Carry"}, Carry, 0);
      checkOutput({tag, " Err"}, Err, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      Reset_n   = 1'b0;
      In_valid  = 1'b0;
      Out_ready = 1'b1;
      OP        = 4'd0;
      InputA    = 8'h00;
      InputB    = 8'h00;

      // op, a, b, out, cond, zero, carry, err -- flags chain from one row to the next
      vq.push_back('{ADD,   8'hF0, 8'h20, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0});
      vq.push_back('{SUB,   8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0});
      vq.push_back('{SLT,   8'h03, 8'h09, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back('{XOR,   8'h5A, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
      vq.push_back('{LSL,   8'h81, 8'h09, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
      vq.push_back('{ASR,   8'h80, 8'h03, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back('{ASR,   8'h80, 8'hC8, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
      vq.push_back('{4'd13, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1});
      vq.push_back('{ADD,   8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0});
      vq.push_back('{SEQ,   8'h33, 8'h33, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0});
      vq.push_back('{SEQ,   8'h33, 8'h34, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
      vq.push_back('{AND,   8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0});
      vq.push_back('{IOR,   8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0});
      vq.push_back('{NOT,   8'hA5, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0});
      vq.push_back('{LSR,   8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0});
      vq.push_back('{LSR,   8'h80, 8'h08, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
      vq.push_back('{SUB,   8'h07, 8'h07, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
      vq.push_back('{SLT,   8'h09, 8'h03, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
      vq.push_back('{LSL,   8'h03, 8'h01, 8'h06, 1'b0, 1'b0, 1'b1, 1'b0});
      vq.push_back('{ASR,   8'h40, 8'h01, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0});
      vq.push_back('{4'd15, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1});
      vq.push_back('{4'd12, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1});
      vq.push_back('{ADD,   8'h10, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0});

      repeat (2) @(negedge Clk);
      checkIdleReset("reset");
      Reset_n = 1'b1;
      @(negedge Clk);

      // Stream the table with Out_ready high: each row is accepted on consecutive edges.
      foreach (vq[i]) begin
         applyStimulus(vq[i].op, vq[i].a, vq[i].b);
         @(posedge Clk);
         @(negedge Clk);
         checkOutput($sformatf("v%0d Out_valid", i), Out_valid, 1);
         checkOutput($sformatf("v%0d In_ready", i), In_ready, 1);
         checkOutput($sformatf("v%0d Out", i), Out, vq[i].out);
         checkOutput($sformatf("v%0d OutHi", i), OutHi, 0);
         checkOutput($sformatf("v%0d Cond", i), Cond, vq[i].cond);
         checkOutput($sformatf("v%0d Zero", i), Zero, vq[i].zero);
         checkOutput($sformatf("v%0d Carry", i), Carry, vq[i].carry);
         checkOutput($sformatf("v%0d Err", i), Err, vq[i].err);
      end
      In_valid = 1'b0;
      @(negedge Clk);
      checkOutput("drain Out_valid", Out_valid, 0);

      // MUL 0xFF*0xFF with a follow-up ADD waiting behind it and the consumer stalled.
      Out_ready = 1'b0;
      applyStimulus(MUL, 8'hFF, 8'hFF);
      @(posedge Clk);
      @(negedge Clk);
      applyStimulus(ADD, 8'h02, 8'h03);
`ifdef ALU_MUL_EN
      for (int k = 1; k < 9; k++) begin
         checkOutput($sformatf("mul busy%0d Out_valid", k), Out_valid, 0);
         checkOutput($sformatf("mul busy%0d In_ready", k), In_ready, 0);
         @(negedge Clk);
      end
`endif
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("mul hold%0d Out_valid", k), Out_valid, 1);
         checkOutput($sformatf("mul hold%0d In_ready", k), In_ready, 0);
         checkOutput($sformatf("mul hold%0d Out", k), Out, MUL_LO);
         checkOutput($sformatf("mul hold%0d OutHi", k), OutHi, MUL_HI);
         checkOutput($sformatf("mul hold%0d Zero", k), Zero, MUL_ZERO);
         checkOutput($sformatf("mul hold%0d Err", k), Err, MUL_ERR);
         @(negedge Clk);
      end
      Out_ready = 1'b1;
      #1;
      checkOutput("mul release In_ready", In_ready, 1);
      @(posedge Clk);
      @(negedge Clk);
      In_valid = 1'b0;
      checkOutput("after mul Out_valid", Out_valid, 1);
      checkOutput("after mul Out", Out, 8'h05);
      checkOutput("after mul OutHi", OutHi, 0);
      checkOutput("after mul Err", Err, 0);
      checkOutput("after mul Carry", Carry, 0);
      @(negedge Clk);

      // Reset in the middle of a multiply must leave no result behind.
      applyStimulus(MUL, 8'h03, 8'h04);
      @(posedge Clk);
      @(negedge Clk);
      In_valid = 1'b0;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      checkIdleReset("abort");
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge Clk);
         checkOutput($sformatf("abort idle%0d Out_valid", k), Out_valid, 0);
      end
      checkOutput("abort final Out", Out, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Next-generation ALU for the datapath, parametrised in width W.
- Registers every result behind a valid/ready handshake and keeps Cond, Zero and Carry in flag registers.
- Adds a multi-cycle iterative unsigned multiply (MUL) and an arithmetic shift right (ASR).
- Sits between the register file read ports and the writeback mux; the control unit drives In_valid and samples Out_valid.

Parameters:
- W, 8, data width of InputA, InputB, Out and OutHi.
- Ops, 4, opcode width; must be at least 4.

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous active-low reset
- In_valid  input  1  operands and OP are presented
- In_ready  output  1  block can accept a new operation this cycle
- InputA  input  W  operand A
- InputB  input  W  operand B (also the shift amount)
- OP  input  Ops  opcode, type op_mne
- Out_valid  output  1  result registers hold a result
- Out_ready  input  1  consumer takes the result this cycle
- Out  output  W  result; low half of the product for MUL
- OutHi  output  W  high half of the product for MUL, 0 for all other ops
- Cond  output  1  registered condition from SLT/SEQ
- Zero  output  1  registered: Out == 0
- Carry  output  1  registered carry from ADD/SUB
- Err  output  1  registered: last accepted OP was illegal

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE; Out, OutHi, Cond, Zero, Carry, Err, Out_valid all 0; multiply counter 0.
  - A reset during MUL aborts it; no result is produced.
- Opcodes: ADD=0, SUB=1, AND=2, IOR=3, NOT=4, XOR=5, LSL=6, LSR=7, SLT=8, SEQ=9, MUL=10, ASR=11. Codes 12-15 are illegal.
- States:
  - IDLE: ready for a new operation.
  - MUL: iterative multiply in progress.
  - RESP: result held.
- Handshake:
  - In_ready = (state==IDLE) | (state==RESP & Out_ready).
  - An operation is accepted on In_valid & In_ready, and the operands and OP are captured on that edge.
  - Non-MUL op: result is registered on the accept edge; next state is RESP; Out_valid=1 the following cycle (latency 1).
  - MUL: next state is MUL. A counter runs W cycles of shift-add; then state goes to RESP. Out_valid rises W+1 cycles after accept.
  - RESP: Out_valid holds with stable outputs until Out_ready=1.
    - If In_valid is also 1, the new op is accepted on the same edge (back-to-back; no bubble for single-cycle ops).
    - Otherwise state goes to IDLE and Out_valid drops.
  - In MUL, In_ready=0; In_valid is ignored.
- Arithmetic, all results truncated to W bits:
  - ADD: Carry = bit W of A+B.
  - SUB: A+~B+1, with Carry = no-borrow (A>=B).
  - SLT (unsigned A<B) and SEQ: Out = 1 or 0, and Cond takes the same value.
- Shifts:
  - The shift amount is the full unsigned B.
  - If B>=W: LSL and LSR give 0; ASR gives all copies of A[W-1].
- MUL: {OutHi,Out} = A*B, unsigned, 2W bits.
- Flag update rules:
  - Zero updates on every result: Out==0. For MUL, {OutHi,Out}==0.
  - Carry updates only on ADD/SUB; otherwise it holds.
  - Cond updates only on SLT/SEQ; otherwise it holds.
- Illegal OP: Out=0, OutHi=0, Err=1, Zero=1, Cond and Carry hold, latency 1. Err clears on the next legal accept.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: MUL works as specified above.
- Undefined: no multiplier hardware and the MUL state is unreachable; OP=10 is treated exactly as an illegal opcode (Err=1, latency 1).

Decomposition:
- Package Definitions:
  - extend op_mne with MUL and ASR;
  - add typedef alu_state_t {IDLE, MUL, RESP};
  - add constants for the illegal-op range.
- Sub-module alu_mul_iter: start/busy/done interface, W-cycle shift-add, 2W-bit product. It is instantiated only under ALU_MUL_EN.

Test Plan (W=8):
- Reset: assert Reset_n=0 mid-MUL, release -> state IDLE, all outputs 0, In_ready=1; no stale Out_valid.
- ADD back-to-back:
  - A=0xF0, B=0x20, then SUB A=0x05, B=0x07, with Out_ready held at 1.
  - Required: Out=0x10, Carry=1 on cycle 1; then Out=0xFE, Carry=0 on cycle 2, with no bubble.
- SLT and flag hold:
  - SLT A=3, B=9 -> Out=1, Cond=1.
  - Then XOR A=B=0x5A -> Out=0, Zero=1, Cond stays 1.
- Shifts:
  - LSL A=0x81, B=9 -> Out=0.
  - ASR A=0x80, B=3 -> Out=0xF0.
  - ASR A=0x80, B=200 -> Out=0xFF.
- MUL with backpressure:
  - A=0xFF, B=0xFF, Out_ready=0 for 3 cycles after Out_valid.
  - Required: Out_valid at accept+9; Out=0x01, OutHi=0xFE held stable; In_ready=0 throughout.
  - Without ALU_MUL_EN: Err=1 at accept+1.
- Illegal OP=13 -> Err=1, Out=0; then a legal ADD clears Err to 0.
